// File: rtl/instr_sequencer.sv
// instr_sequencer: multi-cycle fetch/decode/execute/memory/writeback control FSM with memory timeout
module instr_sequencer #(
  parameter int MEM_TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       run,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  input  logic       alu_done,
  input  logic       branch_cond,
  output logic       mem_req,
  output logic       mem_we,
  output logic       pc_inc,
  output logic       pc_load,
  output logic       ir_load,
  output logic       mdr_load,
  output logic       alu_start,
  output logic       reg_we,
  output logic       wb_sel,
  output logic [1:0] seu_sel,
  output logic       busy,
  output logic       halted,
  output logic       err
);
  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT, S_ERROR} state_t;
  typedef enum logic [2:0] {C_RR, C_MUL, C_IMM, C_LD, C_ST, C_BR, C_HLT} cls_t;
  state_t     state_q, state_d, bnd;
  cls_t       cls_q, cls_d, dec_cls;
  logic [7:0] cnt_q, cnt_d;
  logic [1:0] seu_q, seu_d;
  logic       timeout;
  assign dec_cls = opcode == 6'h3f ? C_HLT :
                   opcode[5:4] == 2'b11 ? C_BR :
                   opcode[5:4] == 2'b10 ? (opcode[0] ? C_ST : C_LD) :
                   opcode[5:4] == 2'b01 ? C_IMM :
                   opcode[3] ? C_MUL : C_RR;
  assign bnd     = run ? S_FETCH : S_IDLE;
  assign timeout = !mem_ready && cnt_q == 8'(MEM_TIMEOUT - 1);
  assign seu_sel = seu_q;
  assign busy    = !(state_q inside {S_IDLE, S_HALT, S_ERROR});
  assign halted  = state_q == S_HALT;
  assign err     = state_q == S_ERROR;
  always_comb begin
    state_d   = state_q;
    cls_d     = cls_q;
    seu_d     = seu_q;
    cnt_d     = ((state_q == S_FETCH || state_q == S_MEM) && !mem_ready) ? cnt_q + 8'd1 : 8'd0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    pc_inc    = 1'b0;
    pc_load   = 1'b0;
    ir_load   = 1'b0;
    mdr_load  = 1'b0;
    alu_start = 1'b0;
    reg_we    = 1'b0;
    wb_sel    = 1'b0;
    case (state_q)
      S_IDLE: state_d = bnd;
      S_FETCH: begin
        mem_req = 1'b1;
        ir_load = mem_ready;
        pc_inc  = mem_ready;
        state_d = mem_ready ? S_DECODE : timeout ? S_ERROR : S_FETCH;
      end
      S_DECODE: begin
        cls_d     = dec_cls;
        alu_start = dec_cls == C_MUL;
        seu_d     = dec_cls == C_IMM ? {1'b0, opcode[0]} :
                    (dec_cls == C_LD || dec_cls == C_ST) ? 2'b10 :
                    dec_cls == C_BR ? 2'b11 : seu_q;
        state_d   = dec_cls == C_HLT ? S_HALT : S_EXEC;
      end
      S_EXEC: begin
        pc_load = cls_q == C_BR && branch_cond;
        state_d = cls_q == C_BR ? bnd :
                  (cls_q == C_LD || cls_q == C_ST) ? S_MEM :
                  (cls_q != C_MUL || alu_done) ? S_WB : S_EXEC;
      end
      S_MEM: begin
        mem_req  = 1'b1;
        mem_we   = cls_q == C_ST;
        mdr_load = mem_ready && cls_q == C_LD;
        state_d  = mem_ready ? (cls_q == C_LD ? S_WB : bnd) : timeout ? S_ERROR : S_MEM;
      end
      S_WB: begin
        reg_we  = 1'b1;
        wb_sel  = cls_q == C_LD;
        state_d = bnd;
      end
      default: state_d = state_q;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cls_q   <= C_RR;
      cnt_q   <= 8'd0;
      seu_q   <= 2'b00;
    end else begin
      state_q <= state_d;
      cls_q   <= cls_d;
      cnt_q   <= cnt_d;
      seu_q   <= seu_d;
    end
  end
endmodule

// File: tb/tb_instr_sequencer.sv
// tb_instr_sequencer: directed per-cycle strobe, latency and seu_sel checks for instr_sequencer
module tb_instr_sequencer;
  logic clk = 1'b0, rst_n = 1'b0, run = 1'b0, mem_ready = 1'b0, alu_done = 1'b0, branch_cond = 1'b0;
  logic [5:0] opcode = 6'd0;
  logic mem_req, mem_we, pc_inc, pc_load, ir_load, mdr_load, alu_start, reg_we, wb_sel, busy, halted, err;
  logic [1:0] seu_sel;
  logic [11:0] ov;
  int n_vec = 0, n_err = 0;
  localparam logic [11:0] REQ = 12'h800, WE = 12'h400, PCI = 12'h200, PCL = 12'h100, IRL = 12'h080,
                          MDR = 12'h040, ALS = 12'h020, RWE = 12'h010, WBS = 12'h008, BSY = 12'h004,
                          HLT = 12'h002, ERR = 12'h001, NONE = 12'h000;
  localparam int K_RR = 0, K_MUL = 1, K_IMM = 2, K_LD = 3, K_ST = 4, K_BR = 5;
  assign ov = {mem_req, mem_we, pc_inc, pc_load, ir_load, mdr_load, alu_start, reg_we, wb_sel, busy, halted, err};
  always #5 clk = ~clk;
  instr_sequencer #(.MEM_TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .opcode(opcode), .mem_ready(mem_ready), .alu_done(alu_done),
    .branch_cond(branch_cond), .mem_req(mem_req), .mem_we(mem_we), .pc_inc(pc_inc), .pc_load(pc_load),
    .ir_load(ir_load), .mdr_load(mdr_load), .alu_start(alu_start), .reg_we(reg_we), .wb_sel(wb_sel),
    .seu_sel(seu_sel), .busy(busy), .halted(halted), .err(err)
  );
  task automatic chk(input string tag, input logic [11:0] got, input logic [11:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic cyc(input logic mr, input logic ad, input logic bc);
    @(negedge clk);
    mem_ready = mr;
    alu_done = ad;
    branch_cond = bc;
    #1;
  endtask
  // Runs one non-HLT instruction starting in its first FETCH cycle.
  task automatic instr(input string tg, input logic [5:0] op, input int k, input int fw, input int mw,
                       input int aw, input logic bc, input logic drop, input logic [1:0] seu_exp, input int lat_exp);
    int lat = 0;
    opcode = op;
    for (int i = 0; i <= fw; i++) begin
      cyc(i == fw, 1'b0, 1'b0);
      chk({tg, ".fetch"}, ov, REQ | BSY | (i == fw ? (PCI | IRL) : NONE));
      lat++;
    end
    cyc(1'b1, 1'b1, 1'b0);
    chk({tg, ".decode"}, ov, BSY | (k == K_MUL ? ALS : NONE));
    lat++;
    if (drop) run = 1'b0;
    if (k == K_MUL) begin
      for (int i = 0; i <= aw; i++) begin
        cyc(1'b1, i == aw, bc);
        chk({tg, ".exec"}, ov, BSY);
        if (i == 0) chk({tg, ".seu"}, {10'd0, seu_sel}, {10'd0, seu_exp});
        lat++;
      end
    end else begin
      cyc(1'b1, 1'b1, bc);
      chk({tg, ".exec"}, ov, BSY | (k == K_BR && bc ? PCL : NONE));
      chk({tg, ".seu"}, {10'd0, seu_sel}, {10'd0, seu_exp});
      lat++;
    end
    if (k == K_LD || k == K_ST) begin
      for (int i = 0; i <= mw; i++) begin
        cyc(i == mw, 1'b1, 1'b0);
        chk({tg, ".mem"}, ov, REQ | BSY | (k == K_ST ? WE : NONE) | (k == K_LD && i == mw ? MDR : NONE));
        lat++;
      end
    end
    if (k != K_BR && k != K_ST) begin
      cyc(1'b0, 1'b1, 1'b0);
      chk({tg, ".wb"}, ov, RWE | BSY | (k == K_LD ? WBS : NONE));
      lat++;
    end
    chk({tg, ".seu_end"}, {10'd0, seu_sel}, {10'd0, seu_exp});
    chk({tg, ".lat"}, 12'(lat), 12'(lat_exp));
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
  initial begin
    run = 1'b1;
    @(negedge clk);
    #1;
    chk("rst", ov, NONE);
    chk("rst.seu", {10'd0, seu_sel}, 12'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("idle0", ov, NONE);
    instr("imm",  6'b010001, K_IMM, 0, 0, 0, 1'b0, 1'b0, 2'b01, 4);
    instr("ld",   6'b100000, K_LD,  0, 3, 0, 1'b0, 1'b0, 2'b10, 8);
    instr("br1",  6'b110000, K_BR,  0, 0, 0, 1'b1, 1'b0, 2'b11, 3);
    instr("br0",  6'b110000, K_BR,  0, 0, 0, 1'b0, 1'b0, 2'b11, 3);
    instr("mul",  6'b001010, K_MUL, 0, 0, 5, 1'b0, 1'b0, 2'b11, 9);
    instr("mul0", 6'b001111, K_MUL, 0, 0, 0, 1'b1, 1'b0, 2'b11, 4);
    instr("rr",   6'b000011, K_RR,  0, 0, 0, 1'b1, 1'b0, 2'b11, 4);
    instr("st",   6'b100001, K_ST,  0, 2, 0, 1'b0, 1'b0, 2'b10, 6);
    instr("immz", 6'b010000, K_IMM, 2, 0, 0, 1'b0, 1'b0, 2'b00, 6);
    instr("drop", 6'b000000, K_RR,  0, 0, 0, 1'b0, 1'b1, 2'b00, 4);
    cyc(1'b1, 1'b1, 1'b1);
    chk("idle1", ov, NONE);
    cyc(1'b1, 1'b0, 1'b0);
    chk("idle2", ov, NONE);
    run = 1'b1;
    opcode = 6'b111111;
    cyc(1'b1, 1'b0, 1'b0);
    chk("hlt.fetch", ov, REQ | BSY | PCI | IRL);
    cyc(1'b1, 1'b1, 1'b0);
    chk("hlt.decode", ov, BSY);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, 1'b1, 1'b1);
      chk("halt", ov, HLT);
    end
    chk("halt.seu", {10'd0, seu_sel}, 12'd0);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk("rst.halt", ov, NONE);
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("idle3", ov, NONE);
    instr("ld2", 6'b100010, K_LD, 0, 0, 0, 1'b0, 1'b0, 2'b10, 5);
    instr("st3", 6'b100001, K_ST, 0, 3, 0, 1'b0, 1'b0, 2'b10, 7);
    for (int i = 0; i < 4; i++) begin
      cyc(1'b0, 1'b0, 1'b0);
      chk("to.fetch", ov, REQ | BSY);
    end
    cyc(1'b1, 1'b1, 1'b1);
    chk("to.err", ov, ERR);
    cyc(1'b1, 1'b0, 1'b0);
    chk("to.err2", ov, ERR);
    chk("to.seu", {10'd0, seu_sel}, 12'd2);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk("rst.err", ov, NONE);
    chk("rst.err.seu", {10'd0, seu_sel}, 12'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("idle4", ov, NONE);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
